// File: rtl/board_mem_clear_if.sv
// Bus bundle between the game FSM / VGA painter and the playfield store.
// The total_lines signal exists only when BOARD_LINE_TOTAL_EN is defined.
`timescale 1ns/1ps
interface board_mem_clear_if #(
  parameter int XW = 4,
  parameter int YW = 5
);
  logic          board_we;
  logic [XW-1:0] board_wx;
  logic [YW-1:0] board_wy;
  logic          board_wdata;
  logic [XW-1:0] board_rx;
  logic [YW-1:0] board_ry;
  logic          board_rdata;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic          vga_data;
  logic          clear_start;
  logic          clear_busy;
  logic          clear_done;
  logic [4:0]    lines_cleared;
`ifdef BOARD_LINE_TOTAL_EN
  logic [7:0]    total_lines;

  modport master (
    output board_we, board_wx, board_wy, board_wdata, board_rx, board_ry,
           vga_x, vga_y, clear_start,
    input  board_rdata, vga_data, clear_busy, clear_done, lines_cleared, total_lines
  );
  modport slave (
    input  board_we, board_wx, board_wy, board_wdata, board_rx, board_ry,
           vga_x, vga_y, clear_start,
    output board_rdata, vga_data, clear_busy, clear_done, lines_cleared, total_lines
  );
`else
  modport master (
    output board_we, board_wx, board_wy, board_wdata, board_rx, board_ry,
           vga_x, vga_y, clear_start,
    input  board_rdata, vga_data, clear_busy, clear_done, lines_cleared
  );
  modport slave (
    input  board_we, board_wx, board_wy, board_wdata, board_rx, board_ry,
           vga_x, vga_y, clear_start,
    output board_rdata, vga_data, clear_busy, clear_done, lines_cleared
  );
`endif
endinterface

// File: rtl/board_mem_clear.sv
// 10x20 playfield bit store with two combinational read ports and a line-clear engine.
// Optional lifetime line accumulator (total_lines) is enabled by BOARD_LINE_TOTAL_EN.
`timescale 1ns/1ps
module board_mem_clear #(
  parameter int COLS = 10,
  parameter int ROWS = 20,
  parameter int XW   = 4,
  parameter int YW   = 5
) (
  input  logic            CLOCK_50,
  input  logic            resetn,
  board_mem_clear_if.slave bus
);

  localparam logic [XW-1:0] COLS_X   = XW'(COLS);
  localparam logic [YW-1:0] ROWS_Y   = YW'(ROWS);
  localparam logic [YW-1:0] LAST_ROW = YW'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [COLS-1:0] rows_q [ROWS];
  logic [COLS-1:0] rows_d [ROWS];
  logic [YW-1:0]   r_q, r_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [4:0]      lines_q, lines_d;
  logic            wr_ok;

`ifdef BOARD_LINE_TOTAL_EN
  logic [7:0] total_q, total_d;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [4:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {4'b0000, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction
`endif

  assign wr_ok = bus.board_we && (bus.board_wx < COLS_X) && (bus.board_wy < ROWS_Y);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    for (int k = 0; k < ROWS; k++) rows_d[k] = rows_q[k];
`ifdef BOARD_LINE_TOTAL_EN
    total_d = total_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (wr_ok) rows_d[bus.board_wy][bus.board_wx] = bus.board_wdata;
        if (bus.clear_start) begin
          r_d     = LAST_ROW;
          cnt_d   = 5'd0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // A full row collapses everything above it by one; the same index is re-checked.
        if (&rows_q[r_q]) begin
          for (int k = 1; k < ROWS; k++) begin
            if (k <= int'(r_q)) rows_d[k] = rows_q[k-1];
          end
          rows_d[0] = '0;
          cnt_d     = cnt_q + 5'd1;
        end else if (r_q != '0) begin
          r_d = r_q - YW'(1);
        end else begin
          lines_d = cnt_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
`ifdef BOARD_LINE_TOTAL_EN
        total_d = sat_add(total_q, lines_q);
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      for (int k = 0; k < ROWS; k++) rows_q[k] <= '0;
`ifdef BOARD_LINE_TOTAL_EN
      total_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      for (int k = 0; k < ROWS; k++) rows_q[k] <= rows_d[k];
`ifdef BOARD_LINE_TOTAL_EN
      total_q <= total_d;
`endif
    end
  end

  // FSM reads treat off-board cells as wall; the painter sees them as empty.
  assign bus.board_rdata = ((bus.board_rx >= COLS_X) || (bus.board_ry >= ROWS_Y)) ? 1'b1
                         : rows_q[bus.board_ry][bus.board_rx];
  assign bus.vga_data    = ((bus.vga_x >= COLS_X) || (bus.vga_y >= ROWS_Y)) ? 1'b0
                         : rows_q[bus.vga_y][bus.vga_x];

  assign bus.clear_busy    = (state_q != S_IDLE);
  assign bus.clear_done    = (state_q == S_DONE);
  assign bus.lines_cleared = lines_q;
`ifdef BOARD_LINE_TOTAL_EN
  assign bus.total_lines   = total_q;
`endif

endmodule

// File: tb/tb_board_mem_clear.sv
// Self-checking bench for board_mem_clear: randomized boards checked against a row-list model.
`timescale 1ns/1ps
module tb_board_mem_clear;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  board_mem_clear_if #(.XW(4), .YW(5)) bus ();

  board_mem_clear #(.COLS(10), .ROWS(20), .XW(4), .YW(5)) dut (
    .CLOCK_50(clk),
    .resetn  (rstn),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit mdl [20][10];
  int mdl_total = 0;

  task automatic zero_model();
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++) mdl[y][x] = 1'b0;
    mdl_total = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    zero_model();
  endtask

  task automatic write_cell(input int x, input int y, input bit d);
    @(negedge clk);
    bus.board_we    = 1'b1;
    bus.board_wx    = x[3:0];
    bus.board_wy    = y[4:0];
    bus.board_wdata = d;
    @(negedge clk);
    bus.board_we    = 1'b0;
    if (x < 10 && y < 20) mdl[y][x] = d;
  endtask

  task automatic fill_row(input int y);
    for (int x = 0; x < 10; x++) write_cell(x, y, 1'b1);
  endtask

  task automatic check_board(input string name);
    int eb = 0;
    int ev = 0;
    for (int y = 0; y < 20; y++) begin
      for (int x = 0; x < 10; x++) begin
        @(negedge clk);
        bus.board_rx = x[3:0];
        bus.board_ry = y[4:0];
        bus.vga_x    = x[3:0];
        bus.vga_y    = y[4:0];
        #1;
        if (bus.board_rdata !== mdl[y][x]) eb++;
        if (bus.vga_data !== mdl[y][x]) ev++;
      end
    end
    n_chk += 2;
    if (eb != 0) begin
      n_fail++;
      $display("FAIL %s board_rdata: %0d cells differ from model, required 0", name, eb);
    end
    if (ev != 0) begin
      n_fail++;
      $display("FAIL %s vga_data: %0d cells differ from model, required 0", name, ev);
    end
  endtask

  // Reference: survivors keep their order and settle at the bottom; full rows vanish.
  task automatic model_clear(output int n);
    bit nb [20][10];
    bit full;
    int dst;
    n   = 0;
    dst = 19;
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++) nb[y][x] = 1'b0;
    for (int y = 19; y >= 0; y--) begin
      full = 1'b1;
      for (int x = 0; x < 10; x++) if (!mdl[y][x]) full = 1'b0;
      if (full) n++;
      else begin
        for (int x = 0; x < 10; x++) nb[dst][x] = mdl[y][x];
        dst--;
      end
    end
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++) mdl[y][x] = nb[y][x];
    mdl_total = (mdl_total + n > 255) ? 255 : mdl_total + n;
  endtask

  task automatic run_clear(input string name);
    int n;
    int cyc;
    model_clear(n);
    @(negedge clk);
    bus.clear_start = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_start = 1'b0;
    cyc = 1;
    n_chk++;
    if (bus.clear_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_after_start: got %b, required 1", name, bus.clear_busy);
    end
    while (bus.clear_done !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_chk++;
    if (bus.clear_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done_timeout: no clear_done within %0d cycles", name, cyc);
      return;
    end
    if (cyc != 21 + n) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, cyc, 21 + n);
    end
    n_chk++;
    if (bus.lines_cleared !== 5'(n)) begin
      n_fail++;
      $display("FAIL %s lines_at_done: got %0d, required %0d", name, bus.lines_cleared, n);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0 || bus.lines_cleared !== 5'(n)) begin
      n_fail++;
      $display("FAIL %s after_done: busy=%b done=%b lines=%0d, required 0 0 %0d",
               name, bus.clear_busy, bus.clear_done, bus.lines_cleared, n);
    end
`ifdef BOARD_LINE_TOTAL_EN
    n_chk++;
    if (bus.total_lines !== 8'(mdl_total)) begin
      n_fail++;
      $display("FAIL %s total_lines: got %0d, required %0d", name, bus.total_lines, mdl_total);
    end
`endif
    check_board(name);
  endtask

  task automatic check_oob(input int x, input int y);
    @(negedge clk);
    bus.board_rx = x[3:0];
    bus.board_ry = y[4:0];
    bus.vga_x    = x[3:0];
    bus.vga_y    = y[4:0];
    #1;
    n_chk += 2;
    if (bus.board_rdata !== 1'b1) begin
      n_fail++;
      $display("FAIL oob_board(%0d,%0d): got %b, required 1", x, y, bus.board_rdata);
    end
    if (bus.vga_data !== 1'b0) begin
      n_fail++;
      $display("FAIL oob_vga(%0d,%0d): got %b, required 0", x, y, bus.vga_data);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0 || bus.lines_cleared !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b lines=%0d, required 0 0 0",
               bus.clear_busy, bus.clear_done, bus.lines_cleared);
    end
`ifdef BOARD_LINE_TOTAL_EN
    n_chk++;
    if (bus.total_lines !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_total: got %0d, required 0", bus.total_lines);
    end
`endif
    @(negedge clk);
    rstn = 1'b1;
    zero_model();
    check_board("reset_board");
    check_oob(10, 0);
    check_oob(0, 20);
    check_oob(15, 31);
  endtask

  task automatic test_write();
    write_cell(3, 7, 1'b1);
    bus.board_rx = 4'd3;
    bus.board_ry = 5'd7;
    #1;
    n_chk++;
    if (bus.board_rdata !== 1'b1) begin
      n_fail++;
      $display("FAIL write_visible: got %b, required 1", bus.board_rdata);
    end
    write_cell(12, 7, 1'b1);
    check_board("write_oob");
    for (int i = 0; i < 40; i++)
      write_cell(int'($urandom_range(0, 11)), int'($urandom_range(0, 21)), 1'($urandom_range(0, 1)));
    check_board("write_random");
  endtask

  task automatic test_clear_single();
    do_reset();
    fill_row(19);
    write_cell(5, 18, 1'b1);
    run_clear("clear_single");
  endtask

  task automatic test_clear_four();
    do_reset();
    for (int y = 16; y < 20; y++) fill_row(y);
    write_cell(0, 15, 1'b1);
    run_clear("clear_four");
  endtask

  task automatic test_busy_ignore();
    int n;
    int dones = 0;
    do_reset();
    fill_row(19);
    write_cell(5, 18, 1'b1);
    write_cell(2, 10, 1'b1);
    model_clear(n);
    @(negedge clk);
    bus.clear_start = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_start = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i <= 10) begin
        bus.board_we    = 1'b1;
        bus.board_wx    = 4'($urandom_range(0, 9));
        bus.board_wy    = 5'($urandom_range(0, 19));
        bus.board_wdata = 1'b1;
        bus.clear_start = 1'b1;
      end else begin
        bus.board_we    = 1'b0;
        bus.clear_start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.clear_done === 1'b1) begin
        dones++;
        n_chk++;
        if (bus.lines_cleared !== 5'(n)) begin
          n_fail++;
          $display("FAIL busy_lines: got %0d, required %0d", bus.lines_cleared, n);
        end
      end
    end
    n_chk += 2;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL busy_done_count: got %0d pulses, required 1", dones);
    end
    if (bus.clear_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_idle_after: got %b, required 0", bus.clear_busy);
    end
    check_board("busy_board");
    do_reset();
    run_clear("clear_empty");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int y = 16; y < 20; y++) fill_row(y);
    @(negedge clk);
    bus.clear_start = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    n_chk++;
    if (bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0 || bus.lines_cleared !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: busy=%b done=%b lines=%0d, required 0 0 0",
               bus.clear_busy, bus.clear_done, bus.lines_cleared);
    end
    zero_model();
    check_board("reset_mid_board");
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_total();
    do_reset();
    for (int y = 16; y < 20; y++) fill_row(y);
    run_clear("total_first");
    for (int y = 17; y < 20; y++) fill_row(y);
    run_clear("total_second");
`ifdef BOARD_LINE_TOTAL_EN
    n_chk++;
    if (bus.total_lines !== 8'd7) begin
      n_fail++;
      $display("FAIL total_sum: got %0d, required 7", bus.total_lines);
    end
`endif
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      do_reset();
      for (int y = 0; y < 20; y++) begin
        if ($urandom_range(0, 2) == 0) fill_row(y);
        else
          for (int x = 0; x < 10; x++)
            if ($urandom_range(0, 1) == 1) write_cell(x, y, 1'b1);
      end
      run_clear($sformatf("random%0d_a", t));
      run_clear($sformatf("random%0d_b", t));
    end
  endtask

  initial begin
    rstn            = 1'b0;
    bus.board_we    = 1'b0;
    bus.board_wx    = '0;
    bus.board_wy    = '0;
    bus.board_wdata = 1'b0;
    bus.board_rx    = '0;
    bus.board_ry    = '0;
    bus.vga_x       = '0;
    bus.vga_y       = '0;
    bus.clear_start = 1'b0;
    test_reset();
    test_write();
    test_clear_single();
    test_clear_four();
    test_busy_ignore();
    test_reset_mid();
    test_total();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
